// File: rtl/des_counter.sv
`default_nettype none
// ============================================================================
//  Module   : des_counter
//  Purpose  : Free-running WIDTH-bit up/down counter. The direction is
//             selected every cycle by m. The block drives the count value, a
//             combinational terminal-count flag and a one-cycle registered
//             wrap pulse.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH    counter width in bits (>= 2)
//    MAX_VAL  upper count limit. Counting up from MAX_VAL returns to 0, and
//             counting down from 0 returns to MAX_VAL.
//  Ports
//    clk    in   1      rising-edge clock
//    rst    in   1      synchronous, active-high reset (overrides m)
//    m      in   1      mode: 1 = count up, 0 = count down
//    count  out  WIDTH  current count (registered)
//    tc     out  1      terminal count (combinational from m and count)
//    wrap   out  1      one-cycle registered pulse on wrap-around
//  Build option
//    COUNTER_SAT_EN  When this macro is defined, the counter saturates at
//                    MAX_VAL and at 0 instead of wrapping, and wrap is held
//                    at 0.
// ============================================================================
module des_counter #(
  parameter int          WIDTH   = 4,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] C_MAX  = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (count_q == C_MAX);
  assign w_at_zero = (count_q == C_ZERO);

  // Next-state logic. The counter never holds still outside saturation,
  // because there is no enable input.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (m) begin
      if (w_at_max) begin
`ifdef COUNTER_SAT_EN
        count_d = C_MAX;
`else
        count_d = C_ZERO;
        wrap_d  = 1'b1;
`endif
      end else begin
        count_d = count_q + C_ONE;
      end
    end else begin
      if (w_at_zero) begin
`ifdef COUNTER_SAT_EN
        count_d = C_ZERO;
`else
        count_d = C_MAX;
        wrap_d  = 1'b1;
`endif
      end else begin
        count_d = count_q - C_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= C_ZERO;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // tc depends on the live value of m, so a change of direction is visible
  // on tc in the same cycle, before the next edge. In saturating builds, tc
  // stays high while the counter holds at a limit.
  assign tc    = (m && w_at_max) || (!m && w_at_zero);
  assign count = count_q;
  assign wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_des_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_des_counter
//  Purpose  : Scoreboard bench for des_counter. The driver applies rst and m
//             on the falling edge and pushes the expected post-edge outputs.
//             The monitor pops one entry after each rising edge and compares
//             it with the DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_des_counter;

  localparam int WIDTH = 4;
  localparam int MAXV  = 2**WIDTH - 1;

  typedef struct {
    int count;
    bit wrap;
    bit tc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             m   = 1'b1;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state, modelled as plain integers
  int mdl_cnt  = 0;
  bit mdl_wrap = 0;

  des_counter #(.WIDTH(WIDTH), .MAX_VAL(MAXV)) dut (
    .clk   (clk),
    .rst   (rst),
    .m     (m),
    .count (count),
    .tc    (tc),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus, then predict the outputs after the next
  // rising edge.
  task automatic step(input bit r, input bit mm);
    exp_t e;
    @(negedge clk);
    rst = r;
    m   = mm;
    if (r) begin
      mdl_cnt  = 0;
      mdl_wrap = 0;
    end else if (mm) begin
`ifdef COUNTER_SAT_EN
      mdl_wrap = 0;
      mdl_cnt  = (mdl_cnt == MAXV) ? MAXV : mdl_cnt + 1;
`else
      mdl_wrap = (mdl_cnt == MAXV);
      mdl_cnt  = (mdl_cnt + 1) % (MAXV + 1);
`endif
    end else begin
`ifdef COUNTER_SAT_EN
      mdl_wrap = 0;
      mdl_cnt  = (mdl_cnt == 0) ? 0 : mdl_cnt - 1;
`else
      mdl_wrap = (mdl_cnt == 0);
      mdl_cnt  = (mdl_cnt + MAXV) % (MAXV + 1);
`endif
    end
    e.count = mdl_cnt;
    e.wrap  = mdl_wrap;
    // m does not change until the next falling edge, so the tc that the
    // monitor samples combines this m with the new count.
    e.tc    = (mm && mdl_cnt == MAXV) || (!mm && mdl_cnt == 0);
    exp_q.push_back(e);
  endtask

  // Monitor: sample 1 time unit after each active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (count !== WIDTH'(e.count)) begin
        errors++;
        $display("FAIL count @%0t: got %0d expected %0d", $time, count, e.count);
      end
      checks++;
      if (wrap !== e.wrap) begin
        errors++;
        $display("FAIL wrap @%0t: got %b expected %b", $time, wrap, e.wrap);
      end
      checks++;
      if (tc !== e.tc) begin
        errors++;
        $display("FAIL tc @%0t: got %b expected %b (count=%0d m=%b)",
                 $time, tc, e.tc, count, m);
      end
    end
  end

  initial begin
    // Reset with m=1, then count up through one full wrap.
    step(1, 1);
    for (int i = 0; i < MAXV + 2; i++) step(0, 1);
    // Reset with m=0 (tc is high), then count down across the wrap.
    step(1, 0);
    for (int i = 0; i < 2; i++) step(0, 0);
    // Count up to 5, then down twice, then up once.
    step(1, 1);
    for (int i = 0; i < 5; i++) step(0, 1);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    // Count up to 9, reset in the middle of the count, then resume.
    step(1, 1);
    for (int i = 0; i < 9; i++) step(0, 1);
    step(1, 1);
    step(0, 1);
    // Run to saturation and stay there, then go down to 0 and stay there.
    for (int i = 0; i < MAXV + 3; i++) step(0, 1);
    for (int i = 0; i < MAXV + 3; i++) step(0, 0);
    // Random stimulus: m is random, and rst is asserted rarely.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1);
    // Drain the queue within a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
